// File: rtl/spec_readout_ctrl.sv
// Purpose : sequences ARM readout of a ping-pong spectrum buffer, swapping banks on frame completion
// Latency : arm_data_ready rises RAM_LATENCY+1 cycles after a bank swap or an accepted ARM data read
// Backpr. : a bank is held until the ARM acknowledges; frames completing meanwhile are dropped and counted
//
// Ports:
//   clk, rst                         system clock, synchronous active-high reset
//   arm_en, frame_done, wr_bank      enable, accumulator frame-complete pulse, accumulator write bank
//   rd_en, rd_addr, rd_data          buffer RAM read port ({rd_bank, word address})
//   arm_rd_strobe, arm_ack           ARM_DATA read pulse, ARM_ACK level
//   arm_data, arm_addr, arm_data_ready  word presented to the ARM, its index, and its valid flag
//   frames_read, overrun_cnt, rd_err    completed frames (wraps), dropped frames (saturates), sticky read error
module spec_readout_ctrl #(
    parameter int BITWIDTH           = 9,
    parameter int ARM_BUS_DATA_WIDTH = 16,
    parameter int FRAME_WORDS        = 4096,
    parameter int RAM_LATENCY        = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          arm_en,
    input  logic                          frame_done,
    output logic                          wr_bank,
    output logic                          rd_en,
    output logic [BITWIDTH+4:0]           rd_addr,
    input  logic [ARM_BUS_DATA_WIDTH-1:0] rd_data,
    input  logic                          arm_rd_strobe,
    input  logic                          arm_ack,
    output logic [ARM_BUS_DATA_WIDTH-1:0] arm_data,
    output logic [BITWIDTH+3:0]           arm_addr,
    output logic                          arm_data_ready,
    output logic [15:0]                   frames_read,
    output logic [15:0]                   overrun_cnt,
    output logic                          rd_err
);
    localparam int AW = BITWIDTH + 4;
    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_WORDS - 1);
    localparam logic [2:0]    LAT       = 3'(RAM_LATENCY);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREFETCH = 3'd1;
    localparam logic [2:0] S_FETCH    = 3'd2;
    localparam logic [2:0] S_READY    = 3'd3;
    localparam logic [2:0] S_WAIT_ACK = 3'd4;

    logic [2:0]                    state_q, state_d;
    logic [2:0]                    lat_cnt_q, lat_cnt_d;
    logic                          wr_bank_q, wr_bank_d;
    logic                          rd_bank_q, rd_bank_d;
    logic                          rd_en_q, rd_en_d;
    logic [AW:0]                   rd_addr_q, rd_addr_d;
    logic [ARM_BUS_DATA_WIDTH-1:0] arm_data_q, arm_data_d;
    logic [AW-1:0]                 arm_addr_q, arm_addr_d;
    logic                          ready_q, ready_d;
    logic [15:0]                   frames_read_q, frames_read_d;
    logic [15:0]                   overrun_q, overrun_d;
    logic                          rd_err_q, rd_err_d;
    logic                          ack_d_q, ack_d_d;

    logic          ack_rise;
    logic          start_frame;
    logic          overrun_inc;
    logic [AW-1:0] next_addr;

    assign ack_rise  = arm_ack & ~ack_d_q;
    assign next_addr = arm_addr_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        lat_cnt_d     = lat_cnt_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        rd_en_d       = 1'b0;           // read enable is a single-cycle pulse
        rd_addr_d     = rd_addr_q;
        arm_data_d    = arm_data_q;
        arm_addr_d    = arm_addr_q;
        ready_d       = ready_q;
        frames_read_d = frames_read_q;
        overrun_d     = overrun_q;
        rd_err_d      = rd_err_q;
        ack_d_d       = arm_ack;
        start_frame   = 1'b0;
        overrun_inc   = 1'b0;

        if (arm_rd_strobe && !ready_q) begin
            rd_err_d = 1'b1;
        end

        if (!arm_en) begin
            // Disable aborts any readout; banks and counters are left alone.
            state_d = S_IDLE;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (frame_done) begin
                        start_frame = 1'b1;
                    end
                end
                S_PREFETCH, S_FETCH: begin
                    // lat_cnt is 0 in the rd_en cycle, so data is valid once it reaches RAM_LATENCY.
                    if (lat_cnt_q == LAT) begin
                        arm_data_d = rd_data;
                        ready_d    = 1'b1;
                        state_d    = S_READY;
                    end else begin
                        lat_cnt_d = lat_cnt_q + 3'd1;
                    end
                    overrun_inc = frame_done;
                end
                S_READY: begin
                    if (arm_rd_strobe) begin
                        ready_d = 1'b0;
                        if (arm_addr_q < LAST_ADDR) begin
                            arm_addr_d = next_addr;
                            rd_addr_d  = {rd_bank_q, next_addr};
                            rd_en_d    = 1'b1;
                            lat_cnt_d  = 3'd0;
                            state_d    = S_FETCH;
                        end else begin
                            state_d = S_WAIT_ACK;
                        end
                    end
                    overrun_inc = frame_done;
                end
                S_WAIT_ACK: begin
                    if (ack_rise) begin
                        frames_read_d = frames_read_q + 16'd1;
                        state_d       = S_IDLE;
                        // A frame finishing exactly as the bank is released is taken, not dropped.
                        start_frame   = frame_done;
                    end else begin
                        overrun_inc = frame_done;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (start_frame) begin
            rd_bank_d  = wr_bank_q;
            wr_bank_d  = ~wr_bank_q;
            arm_addr_d = '0;
            rd_addr_d  = {wr_bank_q, {AW{1'b0}}};
            rd_en_d    = 1'b1;
            lat_cnt_d  = 3'd0;
            state_d    = S_PREFETCH;
        end

        if (overrun_inc && (overrun_q != 16'hFFFF)) begin
            overrun_d = overrun_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            lat_cnt_q     <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            arm_data_q    <= '0;
            arm_addr_q    <= '0;
            ready_q       <= 1'b0;
            frames_read_q <= '0;
            overrun_q     <= '0;
            rd_err_q      <= 1'b0;
            ack_d_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            lat_cnt_q     <= lat_cnt_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            arm_data_q    <= arm_data_d;
            arm_addr_q    <= arm_addr_d;
            ready_q       <= ready_d;
            frames_read_q <= frames_read_d;
            overrun_q     <= overrun_d;
            rd_err_q      <= rd_err_d;
            ack_d_q       <= ack_d_d;
        end
    end

    assign wr_bank        = wr_bank_q;
    assign rd_en          = rd_en_q;
    assign rd_addr        = rd_addr_q;
    assign arm_data       = arm_data_q;
    assign arm_addr       = arm_addr_q;
    assign arm_data_ready = ready_q;
    assign frames_read    = frames_read_q;
    assign overrun_cnt    = overrun_q;
    assign rd_err         = rd_err_q;
endmodule

// File: tb/tb_spec_readout_ctrl.sv
module tb_spec_readout_ctrl;
    localparam int BW = 9;
    localparam int DW = 16;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm_en;
    logic          frame_done;
    logic          wr_bank;
    logic          rd_en;
    logic [BW+4:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          arm_rd_strobe;
    logic          arm_ack;
    logic [DW-1:0] arm_data;
    logic [BW+3:0] arm_addr;
    logic          arm_data_ready;
    logic [15:0]   frames_read;
    logic [15:0]   overrun_cnt;
    logic          rd_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    spec_readout_ctrl #(
        .BITWIDTH(BW), .ARM_BUS_DATA_WIDTH(DW), .FRAME_WORDS(FW), .RAM_LATENCY(2)
    ) dut (
        .clk(clk), .rst(rst), .arm_en(arm_en), .frame_done(frame_done),
        .wr_bank(wr_bank), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .arm_rd_strobe(arm_rd_strobe), .arm_ack(arm_ack), .arm_data(arm_data),
        .arm_addr(arm_addr), .arm_data_ready(arm_data_ready), .frames_read(frames_read),
        .overrun_cnt(overrun_cnt), .rd_err(rd_err)
    );

    // Buffer RAM model: word content is {bank, addr}, two cycles from rd_en to data.
    logic [DW-1:0] ram_p1 = '0;
    logic [DW-1:0] ram_p2 = '0;
    always @(posedge clk) begin
        if (rd_en) ram_p1 <= DW'(rd_addr);
        ram_p2 <= ram_p1;
    end
    assign rd_data = ram_p2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_fd();
        frame_done = 1'b1;
        step(1);
        frame_done = 1'b0;
    endtask

    task automatic pulse_strobe();
        arm_rd_strobe = 1'b1;
        step(1);
        arm_rd_strobe = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".wr_bank"}, 32'(wr_bank), 0);
        check({tag, ".rd_en"}, 32'(rd_en), 0);
        check({tag, ".rd_addr"}, 32'(rd_addr), 0);
        check({tag, ".arm_data"}, 32'(arm_data), 0);
        check({tag, ".arm_addr"}, 32'(arm_addr), 0);
        check({tag, ".ready"}, 32'(arm_data_ready), 0);
        check({tag, ".frames_read"}, 32'(frames_read), 0);
        check({tag, ".overrun"}, 32'(overrun_cnt), 0);
        check({tag, ".rd_err"}, 32'(rd_err), 0);
    endtask

    // Entered with arm_data_ready=1 at word 0; leaves the controller in WAIT_ACK.
    task automatic read_frame(input logic [31:0] base);
        for (int i = 0; i < FW; i++) begin
            check("rf.ready", 32'(arm_data_ready), 1);
            check("rf.addr", 32'(arm_addr), 32'(i));
            check("rf.data", 32'(arm_data), base + 32'(i));
            pulse_strobe();
            check("rf.ready_drop", 32'(arm_data_ready), 0);
            step(3);
        end
        check("rf.wait_ack", 32'(arm_data_ready), 0);
        check("rf.last_addr", 32'(arm_addr), FW - 1);
    endtask

    initial begin
        rst = 1'b1; arm_en = 1'b0; frame_done = 1'b0; arm_rd_strobe = 1'b0; arm_ack = 1'b0;
        step(2);
        rst = 1'b0;
        check_all_zero("reset");

        // First frame from bank 0.
        arm_en = 1'b1;
        step(1);
        pulse_fd();
        check("swap.wr_bank", 32'(wr_bank), 1);
        check("swap.rd_en", 32'(rd_en), 1);
        check("swap.rd_addr", 32'(rd_addr), 32'h0000);
        check("swap.ready", 32'(arm_data_ready), 0);
        step(1);
        check("pf.rd_en_pulse", 32'(rd_en), 0);
        step(1);
        check("pf.ready_early", 32'(arm_data_ready), 0);
        step(1);
        read_frame(32'h0000);
        arm_ack = 1'b1;
        step(1);
        check("ack.frames_read", 32'(frames_read), 1);
        arm_ack = 1'b0;
        step(1);

        // Second frame from bank 1, with two overruns while READY.
        pulse_fd();
        check("swap2.wr_bank", 32'(wr_bank), 0);
        check("swap2.rd_addr", 32'(rd_addr), 32'h2000);
        step(3);
        pulse_fd();
        step(1);
        pulse_fd();
        check("ovr.cnt", 32'(overrun_cnt), 2);
        check("ovr.wr_bank", 32'(wr_bank), 0);
        read_frame(32'h2000);

        // Ack rising edge coincides with frame_done: release and swap, no overrun.
        arm_ack = 1'b1;
        frame_done = 1'b1;
        step(1);
        arm_ack = 1'b0;
        frame_done = 1'b0;
        check("relswap.overrun", 32'(overrun_cnt), 2);
        check("relswap.frames_read", 32'(frames_read), 2);
        check("relswap.wr_bank", 32'(wr_bank), 1);
        check("relswap.rd_en", 32'(rd_en), 1);
        check("relswap.rd_addr", 32'(rd_addr), 32'h0000);
        step(3);
        check("relswap.ready", 32'(arm_data_ready), 1);
        check("relswap.data", 32'(arm_data), 0);

        // Strobe during FETCH is an error and ignored.
        check("err.clear", 32'(rd_err), 0);
        pulse_strobe();
        pulse_strobe();
        check("err.set", 32'(rd_err), 1);
        check("err.addr_hold", 32'(arm_addr), 1);
        step(2);
        check("err.ready", 32'(arm_data_ready), 1);
        check("err.data", 32'(arm_data), 1);
        step(1);
        pulse_strobe();
        check("adv.addr", 32'(arm_addr), 2);
        step(3);
        check("adv.ready", 32'(arm_data_ready), 1);
        check("adv.data", 32'(arm_data), 2);

        // Disable mid-frame at word 2, then frame_done while disabled.
        arm_en = 1'b0;
        step(1);
        check("abort.ready", 32'(arm_data_ready), 0);
        pulse_fd();
        check("dis.wr_bank", 32'(wr_bank), 1);
        check("dis.overrun", 32'(overrun_cnt), 2);
        arm_en = 1'b1;
        step(1);
        pulse_fd();
        check("reen.wr_bank", 32'(wr_bank), 0);
        check("reen.rd_addr", 32'(rd_addr), 32'h2000);
        check("reen.frames_read", 32'(frames_read), 2);

        // Push overrun to 5, get into FETCH, then reset.
        pulse_fd();
        pulse_fd();
        pulse_fd();
        check("ovr5.cnt", 32'(overrun_cnt), 5);
        check("ovr5.ready", 32'(arm_data_ready), 1);
        pulse_strobe();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_all_zero("rst_fetch");

        // Saturation: one swap cycle, then every further cycle is a drop.
        frame_done = 1'b1;
        step(1 + 65534);
        check("sat.fffe", 32'(overrun_cnt), 32'hFFFE);
        step(1);
        check("sat.ffff", 32'(overrun_cnt), 32'hFFFF);
        step(1);
        frame_done = 1'b0;
        check("sat.hold", 32'(overrun_cnt), 32'hFFFF);
        check("sat.wr_bank", 32'(wr_bank), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
